// File: rtl/alarm_ctrl.sv
// Alarm controller: stores alarm time, detects the match edge and runs
// the idle/ringing/snoozed sequence that drives the buzzer.
module alarm_ctrl #(
  parameter int unsigned SNOOZE_MIN = 9,
  parameter int unsigned RING_MIN   = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] sec_in,
  input  logic [6:0] min_in,
  input  logic [6:0] hrs_in,
  input  logic       min_tick,
  input  logic       set_alarm,
  input  logic [6:0] set_min,
  input  logic [6:0] set_hrs,
  input  logic       alarm_en,
  input  logic       snooze,
  input  logic       stop,
  output logic [6:0] alarm_min,
  output logic [6:0] alarm_hrs,
  output logic       buzz,
  output logic [1:0] state,
  output logic [5:0] snz_left
);

  localparam logic [1:0] IDLE    = 2'b00;
  localparam logic [1:0] RINGING = 2'b01;
  localparam logic [1:0] SNOOZED = 2'b10;

  localparam logic [5:0] SNZ_INIT  = 6'(SNOOZE_MIN);
  localparam logic [5:0] RING_LAST = 6'(RING_MIN - 1);

  logic [1:0] state_q, state_d;
  logic [5:0] ring_q, ring_d;
  logic [5:0] snz_q, snz_d;
  logic [6:0] amin_q, ahrs_q;
  logic       match, match_d, trigger;

  // Compare uses the registers as they stand, so a same-cycle load
  // cannot affect this cycle's match.
  assign match   = (hrs_in == ahrs_q) && (min_in == amin_q)
                && (sec_in == 7'd0);
  assign trigger = match && !match_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ring_q  <= '0;
      snz_q   <= '0;
      amin_q  <= '0;
      ahrs_q  <= '0;
      match_d <= 1'b0;
    end else begin
      state_q <= state_d;
      ring_q  <= ring_d;
      snz_q   <= snz_d;
      match_d <= match;
      if (set_alarm) begin
        amin_q <= set_min;
        ahrs_q <= set_hrs;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    ring_d  = ring_q;
    snz_d   = snz_q;
    if (!alarm_en) begin
      state_d = IDLE;
      ring_d  = '0;
      snz_d   = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (trigger && !stop) begin
            state_d = RINGING;
            ring_d  = '0;
          end
        end
        RINGING: begin
          if (stop) begin
            state_d = IDLE;
          end else if (snooze) begin
            state_d = SNOOZED;
            snz_d   = SNZ_INIT;
          end else if (min_tick) begin
            if (ring_q == RING_LAST) begin
              state_d = IDLE;
              ring_d  = '0;
            end else begin
              ring_d = ring_q + 6'd1;
            end
          end
        end
        SNOOZED: begin
          if (stop) begin
            state_d = IDLE;
            snz_d   = '0;
          end else if (min_tick) begin
            if (snz_q == 6'd1) begin
              state_d = RINGING;
              ring_d  = '0;
              snz_d   = '0;
            end else begin
              snz_d = snz_q - 6'd1;
            end
          end
        end
        default: begin
          state_d = IDLE;
          ring_d  = '0;
          snz_d   = '0;
        end
      endcase
    end
  end

  always_comb begin
    state     = state_q;
    buzz      = (state_q == RINGING);
    snz_left  = snz_q;
    alarm_min = amin_q;
    alarm_hrs = ahrs_q;
  end

endmodule

// File: doc/alarm_ctrl.md
Name: alarm_ctrl

Overview:
- Alarm controller downstream of the seconds/minutes/hours mod-N counter chain of the digital clock.
- Consumes the live time values and the minute-rollover pulse; stores a user-set alarm time.
- Runs an IDLE/RINGING/SNOOZED state machine with snooze and auto-timeout.
- Drives the buzzer output and the alarm-time display values.

Parameters:
SNOOZE_MIN, 9, minutes spent in SNOOZED before re-ringing (1..63)
RING_MIN, 5, minutes spent in RINGING before auto-return to IDLE (1..63)

Ports:
clk  input  1  clock
rst  input  1  reset
sec_in  input  7  current seconds, 0..59, from seconds counter
min_in  input  7  current minutes, 0..59
hrs_in  input  7  current hours, 0..23
min_tick  input  1  one-clk pulse when seconds counter wraps 59->0 and is enabled
set_alarm  input  1  load set_min/set_hrs into alarm registers
set_min  input  7  alarm minutes to load
set_hrs  input  7  alarm hours to load
alarm_en  input  1  level; alarm armed when high
snooze  input  1  snooze request, level, sampled each clk
stop  input  1  stop request, level, sampled each clk
alarm_min  output  7  stored alarm minutes
alarm_hrs  output  7  stored alarm hours
buzz  output  1  high exactly while state==RINGING
state  output  2  00 IDLE, 01 RINGING, 10 SNOOZED; 11 unused
snz_left  output  6  remaining snooze minutes; 0 outside SNOOZED

Behaviour:
- Reset: rst is synchronous, active-high, on clock clk. Reset values: alarm_min=0, alarm_hrs=0, state=IDLE, buzz=0, snz_left=0. Ring counter=0, match_d=0.
- rst has priority over every other input, including set_alarm.
- set_alarm: on a clk edge with set_alarm=1, alarm_min<=set_min and alarm_hrs<=set_hrs. Outputs update the next cycle. Loading is legal in any state and never changes state.
- Match: match = (hrs_in==alarm_hrs) && (min_in==alarm_min) && (sec_in==0). Combinational, from current register values.
- match_d: registered copy of match.
- Trigger: trigger = match && !match_d. The rising edge fires once, even though sec_in stays 0 for many clks.
- Transition priority, highest first:
  1. rst
  2. alarm_en==0: state->IDLE, counters cleared
  3. stop
  4. snooze
  5. min_tick
  6. trigger
- IDLE:
  - trigger && alarm_en && !stop -> RINGING; ring counter<=0.
  - buzz rises the cycle after the trigger edge (latency 1).
- RINGING:
  - stop -> IDLE.
  - else snooze -> SNOOZED; snz_left<=SNOOZE_MIN.
  - else on min_tick, ring counter++. When the counter would reach RING_MIN -> IDLE.
  - trigger is ignored.
- SNOOZED:
  - stop -> IDLE; snz_left<=0.
  - snooze and trigger are ignored.
  - On min_tick, snz_left--. On the tick where snz_left==1 -> RINGING; ring counter<=0; snz_left<=0.
- Simultaneity:
  - stop+snooze in RINGING: stop wins.
  - snooze+min_tick in RINGING: snooze wins; the tick is not counted.
  - set_alarm coinciding with trigger: the compare uses the old alarm registers in that cycle.
- Widths: compares are 7-bit unsigned. Ring and snooze counters are 6 bits; no wrap is possible within the parameter range. Inputs outside 0..59/0..23 are compared literally and not checked.
- Reset mid-RINGING or mid-SNOOZED: IDLE next cycle, buzz=0, alarm registers cleared to 00:00.
- Edge case: after rst, time 00:00:00 with alarm 00:00 and alarm_en=1 triggers. This is intended.

Test Plan:
- Set alarm 07:30, alarm_en=1. Drive time 07:29:59 -> 07:30:00 held 50 clks -> buzz rises 1 clk after sec_in hits 0 and stays high; exactly one trigger; state=01.
- In RINGING, pulse snooze 1 clk -> state=10, snz_left=9, buzz=0. Then 9 min_tick pulses -> snz_left 8..1, and on the 9th tick state=01, buzz=1.
- In RINGING, no stop or snooze, 5 min_tick pulses -> buzz drops after the 5th tick; state=00.
- In RINGING, assert stop and snooze in the same cycle -> state=00 next clk, snz_left=0.
- alarm_en=0 while time passes 07:30:00 -> buzz stays 0. Drop alarm_en mid-SNOOZED -> IDLE next clk.
- Assert rst during RINGING with alarm 12:45 -> next clk state=00, buzz=0, alarm_hrs=0, alarm_min=0. set_alarm together with rst -> registers remain 0.
